// File: rtl/data_mem_responder.sv
// Eight-lane data memory responder: accepts one LSU request, services its lanes one per cycle
// against a local word memory, then presents a single response until the consumer takes it.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [7:0]                 req_mask,
  input  logic [7:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0][DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]                 req_warp,
  input  logic [3:0]                 req_reg,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [7:0][DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]                 resp_warp,
  output logic [3:0]                 resp_reg,
  output logic                       resp_write,
  output logic [7:0]                 resp_mask
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                       state_q, state_d;
  logic [2:0]                   lane_q, lane_d;
  logic                         write_q, write_d;
  logic [7:0]                   mask_q, mask_d;
  logic [7:0][ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0][DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]                   warp_q, warp_d;
  logic [3:0]                   rtag_q, rtag_d;
  logic [7:0][DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic                  mem_we;
  logic                  lane_en;
  logic [ADDR_WIDTH-1:0] lane_addr;
  logic [DATA_WIDTH-1:0] lane_wdata;

  assign lane_en    = mask_q[lane_q];
  assign lane_addr  = addr_q[lane_q];
  assign lane_wdata = wdata_q[lane_q];

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    write_d    = write_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    warp_d     = warp_q;
    rtag_d     = rtag_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          mask_d  = req_mask;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          warp_d  = req_warp;
          rtag_d  = req_reg;
          lane_d  = 3'd0;
          rdata_d = '0;
          // An empty mask has nothing to service, so skip the lane walk entirely.
          state_d = (req_mask == 8'h00) ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (lane_en) begin
          if (write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d[lane_q] = mem[lane_addr];
          end
        end
        // The 3-bit index wraps to 0 exactly as the walk hands over to the response.
        lane_d = lane_q + 3'd1;
        if (lane_q == 3'd7) begin
          state_d = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      lane_q  <= 3'd0;
      write_q <= 1'b0;
      mask_q  <= 8'h00;
      addr_q  <= '0;
      wdata_q <= '0;
      warp_q  <= 2'd0;
      rtag_q  <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      warp_q  <= warp_d;
      rtag_q  <= rtag_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately outside the reset domain; an aborted store keeps the lanes it wrote.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[lane_addr] <= lane_wdata;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_warp  = warp_q;
  assign resp_reg   = rtag_q;
  assign resp_write = write_q;
  assign resp_mask  = mask_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, lane data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word address width; memory depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1, the LSU presents a request.
REQ-006 SHALL have port req_ready, output, 1, the block can accept a request.
REQ-007 SHALL have port req_write, input, 1: 1=store, 0=load.
REQ-008 SHALL have port req_mask, input, 8, per-lane enable; bit i enables lane i.
REQ-009 SHALL have port req_addr, input, [ADDR_WIDTH-1:0] x8, per-lane word address.
REQ-010 SHALL have port req_wdata, input, [DATA_WIDTH-1:0] x8, per-lane store data.
REQ-011 SHALL have port req_warp, input, 2, warp tag.
REQ-012 SHALL have port req_reg, input, 4, destination register tag.
REQ-013 SHALL have port resp_valid, output, 1, a response is presented.
REQ-014 SHALL have port resp_ready, input, 1, the consumer accepts the response.
REQ-015 SHALL have port resp_rdata, output, [DATA_WIDTH-1:0] x8, per-lane load data.
REQ-016 SHALL have ports resp_warp (2), resp_reg (4), resp_write (1), resp_mask (8), all outputs, echoing the accepted request.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE.
REQ-019 In IDLE, req_valid=1 SHALL latch all req_* fields, clear lane index to 0, and transition to ACCESS.
REQ-020 If the latched mask is 0x00, the FSM SHALL go IDLE->RESP instead, with resp_rdata all zero.
REQ-021 ACCESS SHALL service exactly one lane per cycle in ascending order 0..7, for a fixed 8 cycles regardless of mask.
REQ-022 For an enabled store lane i, mem[addr[i]] SHALL be written with wdata[i] at that lane's edge.
REQ-023 For an enabled load lane i, resp_rdata[i] SHALL be captured with mem[addr[i]] at that lane's edge.
REQ-024 Disabled lanes SHALL not write memory, and their resp_rdata SHALL be 0.
REQ-025 For stores, resp_rdata SHALL be all zero.
REQ-026 Same-address store lanes SHALL resolve with the highest-numbered enabled lane winning.
REQ-027 A load lane SHALL observe all stores from previously completed requests.
REQ-028 After the lane-7 edge the FSM SHALL enter RESP: resp_valid rises 8 edges after the accepting edge, or 1 edge if the mask is zero.
REQ-029 In RESP, all resp_* outputs SHALL hold stable until resp_valid && resp_ready.
REQ-030 On that handshake edge the FSM SHALL return to IDLE, with resp_valid=0 the next cycle.
REQ-031 req_valid outside IDLE SHALL be ignored, with no latching and no side effects.
REQ-032 resp_ready outside RESP SHALL be ignored.
REQ-033 Lane index is 3 bits and SHALL wrap 7->0 only on the ACCESS->RESP transition.

Reset
REQ-034 reset low SHALL immediately force IDLE, and set req_ready=1 and resp_valid=0.
REQ-035 reset low SHALL zero resp_rdata, resp_warp, resp_reg, resp_write, resp_mask and the lane index.
REQ-036 Memory contents SHALL not be cleared by reset.
REQ-037 Reset mid-ACCESS SHALL abort the request: lanes already written stay written; no response is produced.

Verification
REQ-038 Reset: assert reset low for 3 cycles -> all outputs 0 except req_ready=1; state IDLE after release.
REQ-039 Store/load round trip:
- store, mask 0xFF, addr[i]=0x10+i, wdata[i]=0x1000+i -> resp_valid 8 edges after accept, resp_write=1, rdata all 0;
- then load same addresses -> resp_rdata[i]=0x1000+i, resp_warp/resp_reg echo the request.
REQ-040 Masked load: mask 0x0F from 0x10..0x17 -> lanes 0-3 = 0x1000..0x1003, lanes 4-7 = 0, resp_mask=0x0F.
REQ-041 Store collision:
- all lanes addr 0x20, wdata[i]=i, mask 0xFF;
- then load lane 0 from 0x20 -> 0x0007;
- repeat with mask 0x7F -> 0x0006.
REQ-042 Backpressure and zero mask:
- hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0, a concurrent req_valid is not accepted;
- a zero-mask request -> resp_valid 1 edge after accept.
REQ-043 Reset mid-store: store 0x10+i <- 0xAAAA, pull reset low during the lane-3 ACCESS cycle -> after re-issuing a load, 0x10-0x12 = 0xAAAA and 0x13-0x17 keep their prior values.
